// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU control types, opcode/memc constants and stall FSM states
package alu_pkg;

  typedef enum logic [3:0] {
    CTL_ADD = 4'h0,
    CTL_SUB = 4'h1,
    CTL_AND = 4'h2,
    CTL_OR  = 4'h3,
    CTL_XOR = 4'h4,
    CTL_SLL = 4'h5,
    CTL_SRL = 4'h6,
    CTL_SLT = 4'h7,
    CTL_MUL = 4'h8,
    CTL_DIV = 4'h9
  } control_e;

  localparam logic [3:0] OP_ADD = 4'h0;
  localparam logic [3:0] OP_MUL = 4'h8;
  localparam logic [3:0] OP_DIV = 4'h9;

  localparam logic [1:0] MEMC_NONE  = 2'b00;
  localparam logic [1:0] MEMC_STORE = 2'b01;
  localparam logic [1:0] MEMC_LOAD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MDU_BUSY = 2'd1,
    ST_HALTED   = 2'd2
  } stall_state_e;

  function automatic logic is_mdu_op(input logic [3:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/reg_match_cmp.sv
// rtl/reg_match_cmp.sv - flags a decode source register that matches the EX destination
module reg_match_cmp (
  input  logic [3:0] rs,
  input  logic       rs_used,
  input  logic [3:0] rd,
  input  logic       reg_wr,
  output logic       match
);

  assign match = reg_wr && rs_used && (rs == rd);

endmodule

// File: rtl/stall_ctrl.sv
// rtl/stall_ctrl.sv - pipeline stall, bubble and forwarding control
// STALL_CTRL_MDU_EN enables multi-cycle MUL/DIV occupancy of stage A.
module stall_ctrl
  import alu_pkg::*;
#(
  parameter int MDU_LAT = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       halt_sys,
  input  logic [3:0] id_rs1,
  input  logic [3:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [7:0] ex_instr,
  input  logic       ex_reg_wr,
  input  logic [1:0] ex_memc,
  output logic       stall_fe,
  output logic       stall_a,
  output logic       bubble_a,
  output logic       haz1,
  output logic       haz2,
  output logic       mdu_busy,
  output logic       halted
);

  stall_state_e state;
  logic         halted_q;
  logic         m1;
  logic         m2;
  logic         ex_load;
  logic         load_use;
  logic         mdu_op;
  logic [3:0]   rd;

  assign rd       = ex_instr[3:0];
  assign ex_load  = (ex_memc == MEMC_LOAD);
  assign load_use = ex_load && (m1 || m2);

  reg_match_cmp u_match_rs1 (
    .rs      (id_rs1),
    .rs_used (id_rs1_used),
    .rd      (rd),
    .reg_wr  (ex_reg_wr),
    .match   (m1)
  );

  reg_match_cmp u_match_rs2 (
    .rs      (id_rs2),
    .rs_used (id_rs2_used),
    .rd      (rd),
    .reg_wr  (ex_reg_wr),
    .match   (m2)
  );

`ifdef STALL_CTRL_MDU_EN
  logic [2:0] mdu_cnt;
  logic       busy_q;

  assign mdu_op   = is_mdu_op(ex_instr[7:4]);
  assign mdu_busy = busy_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      halted_q <= 1'b0;
      busy_q   <= 1'b0;
      mdu_cnt  <= 3'd0;
    end else if (halt_sys) begin
      state    <= ST_HALTED;
      halted_q <= 1'b1;
      busy_q   <= 1'b0;
      mdu_cnt  <= 3'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (mdu_op) begin
            state   <= ST_MDU_BUSY;
            busy_q  <= 1'b1;
            mdu_cnt <= 3'(MDU_LAT - 2);
          end
        end
        ST_MDU_BUSY: begin
          // The op leaves EX on the cycle the count reaches zero.
          if (mdu_cnt != 3'd0) begin
            mdu_cnt <= mdu_cnt - 3'd1;
          end else begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end
        end
        ST_HALTED: state <= ST_HALTED;
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end
`else
  logic              unused_ex_op;
  localparam int     unused_mdu_lat = MDU_LAT;

  assign unused_ex_op = ^ex_instr[7:4];
  assign mdu_op       = 1'b0;
  assign mdu_busy     = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      halted_q <= 1'b0;
    end else if (halt_sys) begin
      state    <= ST_HALTED;
      halted_q <= 1'b1;
    end
  end
`endif

  assign halted = halted_q;

  // Hazard outputs are combinational on the decode/EX inputs, so reset must mask them too.
  always_comb begin
    stall_fe = 1'b0;
    stall_a  = 1'b0;
    bubble_a = 1'b0;
    haz1     = 1'b0;
    haz2     = 1'b0;
    if (!rst) begin
      case (state)
        ST_HALTED: begin
          stall_fe = 1'b1;
          stall_a  = 1'b1;
        end
`ifdef STALL_CTRL_MDU_EN
        ST_MDU_BUSY: begin
          stall_fe = (mdu_cnt != 3'd0);
          stall_a  = (mdu_cnt != 3'd0);
        end
`endif
        default: begin
          if (mdu_op) begin
            stall_fe = 1'b1;
            stall_a  = 1'b1;
          end else if (load_use) begin
            stall_fe = 1'b1;
            bubble_a = 1'b1;
          end
        end
      endcase
      if (state != ST_HALTED) begin
        haz1 = m1 && !ex_load;
        haz2 = m2 && !ex_load;
      end
    end
  end

endmodule
